// File: rtl/loader_pkg.sv
// ----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the BRAM UART boot loader.
//   loader_state_t : loader FSM state encoding
//   SYNC_BYTE      : byte that opens (or restarts) a load frame
//   LEN_W          : width of the word-count field carried in the frame header
// ----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // The header carries N as a 16-bit little-endian count.
    localparam int LEN_W = 16;

endpackage

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, idle-high line.
//   i_clk       : clock
//   i_reset_n   : asynchronous active-low reset
//   i_rx        : asynchronous serial input (2-flop synchronized here)
//   o_byte      : last received byte, valid while o_valid is high
//   o_valid     : 1-cycle strobe, cycle after a good stop-bit sample
//   o_frame_err : 1-cycle strobe, cycle after a stop bit sampled low
// Valid/ready: there is no ready; the consumer must take o_byte in the single
// cycle o_valid is high.
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t        state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], i_rx};
        prev_d  = rx_s;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            RX_IDLE: begin
                // A true falling edge is required, so a line still low after a
                // framing error does not immediately launch a bogus byte.
                if (prev_q && !rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    // Line back high at mid start bit: glitch, drop it.
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    valid_d = rx_s;
                    ferr_d  = !rx_s;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_byte      = shift_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;

endmodule

// File: rtl/bram_uart_loader.sv
// ----------------------------------------------------------------------------
// bram_uart_loader
// Boot-time loader feeding bram write port 2 from a framed UART image:
//   A5, N[7:0], N[15:8], N x 4 data bytes (LE words), [checksum byte]
// Words are written from word address 0 upward; the core is held in reset
// until a load completes successfully.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_uart_rx        : serial input, 8N1, idle high
//   o_wr_addr        : word address to bram i_p2_addr
//   o_wr_data        : assembled word to bram i_p2_data
//   o_wr_en          : 1-cycle write strobe to bram i_p2_wren
//   o_core_hold      : core reset / port-2 mux select (high until DONE)
//   o_done, o_err    : outcome of the last load
// Build option: LOADER_CHECKSUM_EN adds the trailing checksum byte (8-bit sum
// of all data bytes) and the CSUM state; without it the load finishes on the
// last data byte.
// ----------------------------------------------------------------------------
module bram_uart_loader
    import loader_pkg::*;
#(
    parameter int MEMSIZE      = 65536,
    parameter int ADDRBIT      = 16,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_uart_rx,
    output logic [ADDRBIT-3:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic              o_wr_en,
    output logic              o_core_hold,
    output logic              o_done,
    output logic              o_err
);

    localparam int ADDR_W = ADDRBIT - 2;
    localparam int unsigned CAPACITY = MEMSIZE / 4;

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_DATA = CSUM;
`else
    localparam loader_state_t AFTER_DATA = DONE;
`endif

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_rx        (i_uart_rx),
        .o_byte      (rx_byte),
        .o_valid     (rx_valid),
        .o_frame_err (rx_ferr)
    );

    loader_state_t     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic [LEN_W-1:0]  n_full;
    logic [31:0]       word_next;

    assign n_full    = {rx_byte, len_q[7:0]};
    assign word_next = {rx_byte, word_q[31:8]};

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        word_d    = word_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif

        if (rx_ferr) begin
            // A corrupt byte inside a frame kills the load; outside a frame
            // it is simply dropped.
            case (state_q)
                LEN0, LEN1, DATA, CSUM: state_d = ERR;
                default: ;
            endcase
        end else if (rx_valid) begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = LEN0;
                        idx_d   = '0;
                        bcnt_d  = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        sum_d   = 8'h00;
`endif
                    end
                end
                LEN0: begin
                    len_d[7:0] = rx_byte;
                    state_d    = LEN1;
                end
                LEN1: begin
                    len_d = n_full;
                    if ({16'd0, n_full} > 32'(CAPACITY)) begin
                        state_d = ERR;
                    end else if (n_full == '0) begin
                        state_d = AFTER_DATA;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    word_d = word_next;
                    bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = sum_q + rx_byte;
`endif
                    if (bcnt_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = word_next;
                        wr_addr_d = idx_q[ADDR_W-1:0];
                        idx_d     = idx_q + 1'b1;
                        if (idx_q == len_q - 1'b1) begin
                            state_d = AFTER_DATA;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    state_d = (rx_byte == sum_q) ? DONE : ERR;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            bcnt_q    <= 2'd0;
            word_q    <= 32'h0;
            wr_addr_q <= '0;
            wr_data_q <= 32'h0;
            wr_en_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            word_q    <= word_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_wr_en     = wr_en_q;
    assign o_done      = (state_q == DONE);
    assign o_err       = (state_q == ERR);
    assign o_core_hold = (state_q != DONE);

endmodule

// File: doc/bram_uart_loader.md
# bram_uart_loader

Boot-time program loader placed directly upstream of the dual-port `bram` write port (port 2). It receives a framed image over a UART RX line, assembles little-endian 32-bit words, and writes them sequentially from word address 0. It holds the RISC-V core in reset until a load completes successfully. After release, the SoC muxes `bram` port 2 back to the core's data path.

## Interface
Parameters:
- `MEMSIZE`, 65536: bram size in bytes; capacity is `MEMSIZE/4` words.
- `ADDRBIT`, 16: byte-address width; the word address is `ADDRBIT-2` bits.
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200).

Ports:
- `i_clk`, in, 1: the single clock.
- `i_reset_n`, in, 1: reset, asynchronous, active-low. This is already decided.
- `i_uart_rx`, in, 1: asynchronous serial input, idle high, 8N1, LSB first.
- `o_wr_addr`, out, ADDRBIT-2: word address to bram `i_p2_addr`.
- `o_wr_data`, out, 32: assembled word to bram `i_p2_data`.
- `o_wr_en`, out, 1: one-cycle write strobe to bram `i_p2_wren`.
- `o_core_hold`, out, 1: keeps the core in reset and selects the loader on the port-2 mux.
- `o_done`, out, 1: the last load completed successfully.
- `o_err`, out, 1: the last load failed (length, framing, or checksum).

## Operation
- Frame format: sync byte `0xA5`, then N as 2 bytes little-endian, then N words of 4 bytes each, little-endian, then a checksum byte (only when the macro is enabled).
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- IDLE: non-`0xA5` bytes are ignored. `0xA5` moves to LEN0.
- LEN0 / LEN1: capture the low and high bytes of N.
  - If N > `MEMSIZE/4`, go to ERR.
  - If N = 0, go to CSUM (or to DONE when the macro is disabled).
  - Otherwise go to DATA.
- DATA:
  - A byte counter of 0–3 shifts bytes into the word, first byte into [7:0].
  - On the 4th byte, issue a write and increment the word index.
  - After word N-1 is written, go to CSUM or DONE.
- CSUM:
  - Compare the received byte with the 8-bit sum (mod 256) of all data bytes. Header bytes are excluded.
  - Equal: go to DONE. Unequal: go to ERR.
- DONE: `o_done`=1, `o_core_hold`=0. A byte `0xA5` restarts the load (go to LEN0, clear `o_done`, assert hold). Other bytes are ignored.
- ERR: `o_err`=1, hold stays 1. A byte `0xA5` restarts the load (clear `o_err`).
- Restart: word index, sum and byte counter are cleared when entering LEN0.
- Framing error (stop bit sampled 0):
  - The byte is discarded.
  - In LEN0, LEN1, DATA or CSUM, go to ERR.
  - In IDLE, DONE or ERR, ignore it.
- Words already written are not rolled back on error.

## Timing
- Reset values:
  - Outputs: `o_wr_addr`=0, `o_wr_data`=0, `o_wr_en`=0, `o_core_hold`=1, `o_done`=0, `o_err`=0.
  - Internal: FSM in IDLE, and the UART receiver idle.
- RX input: `i_uart_rx` passes through a 2-flop synchronizer; reset value 1.
- Start bit: falling edge, re-checked at `CLKS_PER_BIT/2`. If the line is high again, it is treated as a glitch and the receiver returns to idle.
- Data bits: each bit is sampled every `CLKS_PER_BIT` cycles after the start check.
- Byte strobe: the internal byte-valid pulses for 1 cycle, in the cycle after the stop-bit sample.
- Write: `o_wr_en` is high for exactly 1 cycle, the cycle after the byte-valid of the 4th byte. `o_wr_addr` and `o_wr_data` are stable in that cycle and hold their values until the next write.
- `o_done` / `o_err` / `o_core_hold` change 1 cycle after the byte-valid of the deciding byte. When the macro is disabled, "deciding byte" means the last data byte.
- Asynchronous reset mid-frame aborts the load immediately. Any write in flight is dropped.

## Configuration
- `LOADER_CHECKSUM_EN`
  - Defined: CSUM state and 8-bit sum accumulator are present, as above.
  - Undefined: no CSUM state and no accumulator. After the last write (or after LEN1 when N=0) the FSM goes straight to DONE. ERR is reached only on length or framing errors.

## Structure
- Package `loader_pkg`: the FSM state enum `loader_state_t`, the `SYNC_BYTE` constant = `8'hA5`, and the word-count width localparam.
- Sub-module `uart_rx`:
  - Contains the synchronizer, bit timer and shift register.
  - Ports: clock, reset, rx, `o_byte[7:0]`, `o_valid`, `o_frame_err`.
  - The loader FSM, assembler and checksum stay in `bram_uart_loader`.

## Test plan
- Use `CLKS_PER_BIT`=8 for all scenarios.
- Basic load, macro on: send A5 02 00 44 33 22 11 EF BE AD DE E2.
  - Expect writes addr0=0x11223344 and addr1=0xDEADBEEF, each `o_wr_en` exactly 1 cycle.
  - Then `o_done`=1 and hold=0.
- Bad checksum: same frame, last byte 0xE3.
  - Both writes still occur.
  - `o_err`=1, hold=1, `o_done`=0.
  - A following valid frame clears `o_err` and ends with `o_done`=1.
- Length overflow: send A5 01 40 (N=0x4001 > 16384).
  - `o_err`=1 one cycle after the 3rd byte, with no writes.
- Noise and framing:
  - Bytes 00 FF before A5 are ignored.
  - A 1-clock low glitch on rx produces no byte.
  - A stop bit forced to 0 during DATA gives `o_err`=1.
- Reset mid-frame: pull `i_reset_n` low after 2 data bytes.
  - Outputs return to reset values asynchronously.
  - A full frame then loads correctly from addr 0.
- Macro off: send A5 01 00 78 56 34 12.
  - One write, addr0=0x12345678.
  - `o_done`=1 one cycle after the last byte; no checksum byte is expected.
